// File: rtl/dmem_pair_arbiter.sv
// Shares one data-memory port between the two memory lanes of a dual-issue pipeline.
// A same-cycle pair is serialised lane 0 first, with one stall cycle and lane-0 load data held.
module dmem_pair_arbiter #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              rd0,
   input  logic              wr0,
   input  logic [DATA_W-1:0] adr0,
   input  logic [DATA_W-1:0] wdata0,
   input  logic              rd1,
   input  logic              wr1,
   input  logic [DATA_W-1:0] adr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              stall,
   output logic              mem_read,
   output logic              mem_write,
   output logic [DATA_W-1:0] data_adr,
   output logic [DATA_W-1:0] data_out,
   input  logic [DATA_W-1:0] data_in,
   output logic [CNT_W-1:0]  conflict_cnt
);

   typedef enum logic {IDLE, SERVE1} state_t;

   state_t            state, state_nxt;
   logic [DATA_W-1:0] hold0;
   logic [CNT_W-1:0]  cnt;
   logic              req0, req1, conflict;

   assign req0         = rd0 | wr0;
   assign req1         = rd1 | wr1;
   assign conflict     = (state == IDLE) && req0 && req1;
   assign conflict_cnt = cnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         hold0 <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (conflict) begin
            hold0 <= data_in;
            if (cnt != '1)
               cnt <= cnt + 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      data_adr  = adr0;
      data_out  = wdata0;
      rdata0    = data_in;
      rdata1    = data_in;
      stall     = 1'b0;
      case (state)
         IDLE: begin
            if (req0) begin
               mem_read  = rd0;
               mem_write = wr0;
               stall     = req1;
               if (req1)
                  state_nxt = SERVE1;
            end else if (req1) begin
               mem_read  = rd1;
               mem_write = wr1;
               data_adr  = adr1;
               data_out  = wdata1;
            end
         end
         SERVE1: begin
            // Lane-1 inputs are still valid because the previous cycle stalled.
            state_nxt = IDLE;
            rdata0    = hold0;
            data_adr  = adr1;
            data_out  = wdata1;
            if (!flush) begin
               mem_read  = rd1;
               mem_write = wr1;
            end
         end
         default: state_nxt = IDLE;
      endcase
      // Reset dominates: an abandoned lane-1 store must not reach memory.
      if (!rst) begin
         state_nxt = IDLE;
         mem_read  = 1'b0;
         mem_write = 1'b0;
         stall     = 1'b0;
         rdata0    = '0;
         rdata1    = '0;
      end
   end

endmodule

// File: tb/tb_dmem_pair_arbiter.sv
// Bench for dmem_pair_arbiter: directed pair scenarios, then random traffic against
// a pair-level memory model, plus a CNT_W=2 instance for counter saturation.
module tb_dmem_pair_arbiter;

   logic        clk = 1'b0;
   logic        rst, flush, rd0, wr0, rd1, wr1;
   logic [31:0] adr0, wdata0, adr1, wdata1;
   logic [31:0] rdata0, rdata1, data_adr, data_out, data_in;
   logic        stall, mem_read, mem_write;
   logic [15:0] conflict_cnt;

   logic        c2_rd0, c2_rd1, c2_stall, c2_mrd, c2_mwr;
   logic [31:0] c2_zero = 32'h0;
   logic [31:0] c2_r0, c2_r1, c2_adr, c2_dout;
   logic [1:0]  c2_cnt;

   logic [31:0] dmem    [32] = '{default: 32'h0};
   logic [31:0] ref_mem [32] = '{default: 32'h0};

   bit          m_pend = 1'b0;
   bit          m_hv   = 1'b0;
   logic [31:0] m_hold = 32'h0;
   logic [15:0] m_cnt  = 16'h0;

   int n_vec = 0;
   int n_err = 0;
   int seq6 [5] = '{1, 2, 3, 3, 3};

   always #5 clk = ~clk;

   dmem_pair_arbiter #(.DATA_W(32), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .rd0(rd0), .wr0(wr0), .adr0(adr0), .wdata0(wdata0),
      .rd1(rd1), .wr1(wr1), .adr1(adr1), .wdata1(wdata1),
      .rdata0(rdata0), .rdata1(rdata1), .stall(stall),
      .mem_read(mem_read), .mem_write(mem_write),
      .data_adr(data_adr), .data_out(data_out), .data_in(data_in),
      .conflict_cnt(conflict_cnt));

   dmem_pair_arbiter #(.DATA_W(32), .CNT_W(2)) dut_c2 (
      .clk(clk), .rst(rst), .flush(1'b0),
      .rd0(c2_rd0), .wr0(1'b0), .adr0(32'h0), .wdata0(32'h0),
      .rd1(c2_rd1), .wr1(1'b0), .adr1(32'h4), .wdata1(32'h0),
      .rdata0(c2_r0), .rdata1(c2_r1), .stall(c2_stall),
      .mem_read(c2_mrd), .mem_write(c2_mwr),
      .data_adr(c2_adr), .data_out(c2_dout), .data_in(c2_zero),
      .conflict_cnt(c2_cnt));

   // Data memory seen by the DUT: combinational read, write at posedge.
   assign data_in = dmem[data_adr[6:2]];
   always @(posedge clk)
      if (mem_write) dmem[data_adr[6:2]] <= data_out;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                         input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
      rd0 = r0; wr0 = w0; adr0 = a0; wdata0 = d0;
      rd1 = r1; wr1 = w1; adr1 = a1; wdata1 = d1;
   endtask

   // Pair-level model: each cycle is either reset, the deferred lane-1 half of a
   // serialised pair, or a fresh pair issue; memory effects applied in program order.
   always @(negedge clk) begin : model
      logic        sv, s_l1, s_chk, s_rd, s_wr;
      logic [31:0] s_a, s_d, s_exp;
      sv = 1'b0; s_l1 = 1'b0; s_chk = 1'b1;
      if ((rd0 && wr0) || (rd1 && wr1)) begin
         n_err++;
         $display("FAIL illegal_req: rd0/wr0=%b%b rd1/wr1=%b%b", rd0, wr0, rd1, wr1);
      end
      chk("conflict_cnt", conflict_cnt, m_cnt);
      if (!rst) begin
         chk("rst_stall", stall, 0);
         chk("rst_mem_read", mem_read, 0);
         chk("rst_mem_write", mem_write, 0);
         chk("rst_rdata0", rdata0, 0);
         chk("rst_rdata1", rdata1, 0);
         m_pend = 1'b0;
         m_cnt  = 16'h0;
      end else if (m_pend) begin
         chk("stall_second", stall, 0);
         if (m_hv) chk("rdata0_held", rdata0, m_hold);
         if (flush) begin
            chk("flush_mem_read", mem_read, 0);
            chk("flush_mem_write", mem_write, 0);
         end else begin
            sv = 1'b1; s_l1 = 1'b1;
         end
         m_pend = 1'b0;
      end else if ((rd0 | wr0) && (rd1 | wr1)) begin
         chk("stall_conflict", stall, 1);
         m_hold = ref_mem[adr0[6:2]];
         m_hv   = rd0;
         if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h1;
         m_pend = 1'b1;
         sv = 1'b1; s_chk = 1'b0;
      end else if (rd0 | wr0) begin
         chk("stall_single0", stall, 0);
         sv = 1'b1;
      end else if (rd1 | wr1) begin
         chk("stall_single1", stall, 0);
         sv = 1'b1; s_l1 = 1'b1;
      end else begin
         chk("idle_stall", stall, 0);
         chk("idle_mem_read", mem_read, 0);
         chk("idle_mem_write", mem_write, 0);
         chk("idle_data_adr", data_adr, adr0);
      end
      if (sv) begin
         s_rd = s_l1 ? rd1 : rd0;
         s_wr = s_l1 ? wr1 : wr0;
         s_a  = s_l1 ? adr1 : adr0;
         s_d  = s_l1 ? wdata1 : wdata0;
         s_exp = ref_mem[s_a[6:2]];
         chk("mem_read", mem_read, s_rd);
         chk("mem_write", mem_write, s_wr);
         chk("data_adr", data_adr, s_a);
         if (s_wr) begin
            chk("data_out", data_out, s_d);
            ref_mem[s_a[6:2]] = s_d;
         end
         if (s_rd && s_chk)
            chk(s_l1 ? "rdata1" : "rdata0", s_l1 ? rdata1 : rdata0, s_exp);
      end
   end

   initial begin
      rst = 1'b0; flush = 1'b0; c2_rd0 = 1'b0; c2_rd1 = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      cyc();
      @(negedge clk);
      chk("t0_reset_cnt", {16'h0, conflict_cnt}, 0);
      chk("t0_reset_stall", stall, 0);
      cyc();
      rst = 1'b1;

      // 1: lane-0 store then lane-1 load, no stall
      set_in(0, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0);
      @(negedge clk); chk("t1_st_stall", stall, 0); chk("t1_st_mwr", mem_write, 1);
      cyc();
      set_in(0, 0, 0, 0, 1, 0, 32'h10, 0);
      @(negedge clk); chk("t1_ld_stall", stall, 0); chk("t1_rdata1", rdata1, 32'hDEADBEEF);
      cyc();

      // 2: same-cycle store/load to one address
      set_in(0, 1, 32'h20, 32'h11111111, 1, 0, 32'h20, 0);
      @(negedge clk); chk("t2_stall", stall, 1); chk("t2_cnt_before", conflict_cnt, 0);
      cyc();
      @(negedge clk); chk("t2_stall2", stall, 0); chk("t2_rdata1", rdata1, 32'h11111111);
      chk("t2_cnt", conflict_cnt, 1);
      cyc();

      // 3: two loads, lane-0 data held
      set_in(0, 1, 32'h30, 32'hA5A5A5A5, 0, 0, 0, 0); cyc();
      set_in(0, 1, 32'h34, 32'h5A5A5A5A, 0, 0, 0, 0); cyc();
      set_in(1, 0, 32'h30, 0, 1, 0, 32'h34, 0);
      @(negedge clk); chk("t3_stall", stall, 1);
      cyc();
      @(negedge clk); chk("t3_rdata0", rdata0, 32'hA5A5A5A5); chk("t3_rdata1", rdata1, 32'h5A5A5A5A);
      cyc();

      // 4: flushed lane-1 store
      set_in(1, 0, 32'h44, 0, 0, 1, 32'h40, 32'hFFFFFFFF);
      cyc();
      flush = 1'b1;
      @(negedge clk); chk("t4_mwr", mem_write, 0);
      cyc();
      flush = 1'b0;
      set_in(1, 0, 32'h40, 0, 0, 0, 0, 0);
      @(negedge clk); chk("t4_rdata0", rdata0, 32'h0); chk("t4_mem40", dmem[16], 32'h0);
      cyc();

      // 5: reset during the lane-1 half
      set_in(1, 0, 32'h10, 0, 0, 1, 32'h14, 32'h12345678);
      cyc();
      rst = 1'b0;
      @(negedge clk); chk("t5_mwr", mem_write, 0); chk("t5_stall", stall, 0);
      cyc();
      rst = 1'b1;
      set_in(1, 0, 32'h14, 0, 0, 0, 0, 0);
      @(negedge clk); chk("t5_cnt", conflict_cnt, 0); chk("t5_stall2", stall, 0);
      chk("t5_rdata0", rdata0, 32'h0);
      cyc();
      set_in(0, 0, 0, 0, 0, 0, 0, 0);

      // 6: 2-bit counter saturation over back-to-back conflicts
      c2_rd0 = 1'b1; c2_rd1 = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk); chk($sformatf("t6_stall_%0d", k), c2_stall, 1);
         cyc();
         @(negedge clk); chk($sformatf("t6_stall2_%0d", k), c2_stall, 0);
         chk($sformatf("t6_cnt_%0d", k), {30'h0, c2_cnt}, seq6[k]);
         cyc();
      end
      c2_rd0 = 1'b0; c2_rd1 = 1'b0;

      // Random traffic; inputs stay frozen through the lane-1 half of a pair.
      for (int i = 0; i < 3000; i++) begin
         rst   = ($urandom_range(0, 39) != 0);
         flush = ($urandom_range(0, 3) == 0);
         if (!m_pend) begin
            int op0, op1;
            op0 = $urandom_range(0, 2);
            op1 = $urandom_range(0, 2);
            set_in(op0 == 1, op0 == 2, {25'h0, 5'($urandom_range(0, 31)), 2'b00}, $urandom,
                   op1 == 1, op1 == 2, {25'h0, 5'($urandom_range(0, 31)), 2'b00}, $urandom);
         end
         cyc();
      end

      rst = 1'b1; flush = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      cyc();
      @(negedge clk);
      for (int j = 0; j < 32; j++)
         chk($sformatf("mem_final_%0d", j), dmem[j], ref_mem[j]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
